// File: rtl/alu_seq_top.sv
// Board-level ALU lab top: a debounced EXEC press runs one ALU op on latched operands, and the result register doubles as the accumulator.
// Latency: Y, Cout and OV update, with a one-cycle done pulse, 2 clk after the press pulse cycle; the display is purely combinational from the scan index.
// Backpressure: none. Presses that arrive while an op is in flight or the button is still held are ignored, so each debounced press runs exactly one op.
module alu_seq_top #(
  parameter int N            = 4,
  parameter int DEBOUNCE_CYC = 250000,
  parameter int SCAN_DIV     = 50000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         A,
  input  logic [N-1:0]         B,
  input  logic [3:0]           F,
  input  logic                 exec_btn,
  output logic [N-1:0]         Y,
  output logic                 Cout,
  output logic                 OV,
  output logic                 busy,
  output logic                 done,
  output logic [7:0]           op_cnt,
  output logic [6:0]           seg,
  output logic [3*(N/4)-1:0]   an
);

  // Digits per displayed value, and total digits on the bank.
  localparam int D    = N / 4;
  localparam int NDIG = 3 * D;

  // Counter widths. The debounce counter only needs to reach DEBOUNCE_CYC-1.
  localparam int DB_W = $clog2(DEBOUNCE_CYC);
  localparam int SC_W = $clog2(SCAN_DIV + 1);
  localparam int IX_W = $clog2(NDIG + 1);

  localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [SC_W-1:0] SCAN_LAST = SC_W'(SCAN_DIV - 1);
  localparam logic [IX_W-1:0] IDX_LAST  = IX_W'(NDIG - 1);

  // FSM states
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  // ------------------------------------------------------------------
  // Button path
  // ------------------------------------------------------------------
  logic            sync_q1;
  logic            sync_q2;
  logic [DB_W-1:0] db_cnt;
  logic            db_lvl;
  logic            db_prev;
  logic            press;

  // Two-flop synchroniser for the raw, asynchronous pushbutton.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= exec_btn;
      sync_q2 <= sync_q1;
    end
  end

  // Count consecutive synced samples that disagree with the accepted level.
  // Any sample that agrees clears the count; the level flips once DEBOUNCE_CYC
  // disagreeing samples have arrived in a row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_cnt <= '0;
      db_lvl <= 1'b0;
    end else if (sync_q2 == db_lvl) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_LAST) begin
      db_lvl <= sync_q2;
      db_cnt <= '0;
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end
  end

  // Delayed copy of the debounced level, used for rising-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_prev <= 1'b0;
    end else begin
      db_prev <= db_lvl;
    end
  end

  // One-cycle press pulse on a debounced 0->1 transition.
  assign press = db_lvl & ~db_prev;

  // ------------------------------------------------------------------
  // Operand latch and ALU datapath
  // ------------------------------------------------------------------
  logic [1:0]   state;
  logic [N-1:0] ar;
  logic [N-1:0] br;
  // Only the invert and opcode bits are needed after the latch; F[3] is
  // consumed while choosing the A operand.
  logic [2:0]   fr;

  logic [N-1:0] bx;
  logic         cin;
  logic [N:0]   sum_ext;
  logic [N-1:0] sum;
  logic         carry;
  logic         ovf;
  logic [N-1:0] res_y;
  logic         res_c;
  logic         res_ov;

  // Adder shared by ADD/SUB and SLT. Subtraction is A + ~B + 1.
  assign bx      = fr[2] ? ~br : br;
  assign cin     = fr[2];
  assign sum_ext = {1'b0, ar} + {1'b0, bx} + {{N{1'b0}}, cin};
  assign sum     = sum_ext[N-1:0];
  assign carry   = sum_ext[N];
  assign ovf     = (ar[N-1] == bx[N-1]) & (sum[N-1] != ar[N-1]);

  // Select the result for the latched opcode. Only ADD reports carry and overflow.
  always_comb begin
    res_y  = '0;
    res_c  = 1'b0;
    res_ov = 1'b0;
    case (fr[1:0])
      2'b00: res_y = ar & bx;
      2'b01: res_y = ar | bx;
      2'b10: begin
        res_y  = sum;
        res_c  = carry;
        res_ov = ovf;
      end
      default: begin
        // The true sign of the difference is the sum's MSB corrected by overflow.
        res_y[0] = sum[N-1] ^ ovf;
      end
    endcase
  end

  // Control FSM. Operands are latched on press, so later switch changes do not
  // affect the op. HOLD waits for release so that one press runs exactly one op.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      ar     <= '0;
      br     <= '0;
      fr     <= '0;
      Y      <= '0;
      Cout   <= 1'b0;
      OV     <= 1'b0;
      done   <= 1'b0;
      op_cnt <= 8'd0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (press) begin
            ar    <= F[3] ? Y : A;
            br    <= B;
            fr    <= F[2:0];
            state <= ST_CALC;
          end
        end
        ST_CALC: begin
          Y      <= res_y;
          Cout   <= res_c;
          OV     <= res_ov;
          done   <= 1'b1;
          op_cnt <= op_cnt + 8'd1;
          state  <= ST_HOLD;
        end
        ST_HOLD: begin
          if (!db_lvl) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy = (state != ST_IDLE);

  // ------------------------------------------------------------------
  // Seven-segment scan
  // ------------------------------------------------------------------
  logic [SC_W-1:0] scan_div;
  logic [IX_W-1:0] scan_idx;
  logic [3*N-1:0]  disp;
  logic [3:0]      nib;

  // Hold each digit for SCAN_DIV cycles, then move on to the next, wrapping at the last digit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_div <= '0;
      scan_idx <= '0;
    end else if (scan_div == SCAN_LAST) begin
      scan_div <= '0;
      scan_idx <= (scan_idx == IDX_LAST) ? '0 : scan_idx + 1'b1;
    end else begin
      scan_div <= scan_div + 1'b1;
    end
  end

  // Digit k shows nibble k of {A, B, Y}: the Y digits come first, then B, then A, LSD first.
  assign disp = {A, B, Y};

  // Pick the selected nibble and drive its enable low.
  always_comb begin
    nib = 4'd0;
    an  = '1;
    for (int k = 0; k < NDIG; k++) begin
      if (scan_idx == IX_W'(k)) begin
        nib   = disp[4*k +: 4];
        an[k] = 1'b0;
      end
    end
  end

  // Hex font, segments g..a, active-low.
  always_comb begin
    seg = 7'h7F;
    case (nib)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
      default: seg = 7'h7F;
    endcase
  end

endmodule
